// File: rtl/serial_tx.sv
// serial_tx: framed serial transmitter with one-word holding register
module serial_tx #(
  parameter int BIT_LEN  = 7,
  parameter int IDLE_GAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIT_LEN-1:0] data_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               channel_out,
  output logic               busy,
  output logic               frame_done
);
  localparam int IW = BIT_LEN > 1 ? $clog2(BIT_LEN) : 1;
  localparam int GW = IDLE_GAP > 1 ? $clog2(IDLE_GAP) : 1;
  localparam int FW = BIT_LEN + 3;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [FW-1:0]      sr_q, sr_d;
  logic [BIT_LEN-1:0] hold_q, hold_d;
  logic               empty_q, empty_d, busy_q, done_q;
  logic               accept, gap_last, load;
  // Next state; the frame shifts out of sr_q LSB first with zero fill, so the line drops to 0 after STOP.
  always_comb begin
    accept   = in_valid && empty_q;
    gap_last = state_q == GAP && gap_q == '0;
    load     = !empty_q && (state_q == IDLE || gap_last);
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    sr_d     = {1'b0, sr_q[FW-1:1]};
    hold_d   = accept ? data_in : hold_q;
    empty_d  = accept ? 1'b0 : load ? 1'b1 : empty_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      START:   begin state_d = DATA; idx_d = '0; end
      DATA:    begin idx_d = idx_q + 1'b1; state_d = idx_q == IW'(BIT_LEN - 1) ? PARITY : DATA; end
      PARITY:  state_d = STOP;
      STOP:    begin state_d = GAP; gap_d = GW'(IDLE_GAP - 1); end
      GAP:     begin gap_d = gap_q - 1'b1; state_d = gap_last ? IDLE : GAP; end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      sr_d    = {1'b1, ^hold_q, hold_q, 1'b1};
    end
  end
  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      sr_q    <= '0;
      hold_q  <= '0;
      empty_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      empty_q <= empty_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == GAP && gap_d == '0;
    end
  end
  assign in_ready    = empty_q;
  assign channel_out = sr_q[0];
  assign busy        = busy_q;
  assign frame_done  = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: queue-based line model, per-cycle compare, frame decoder and directed literals
module tb_serial_tx;
  localparam int BL = 7;
  localparam int GAPN = 1;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [BL-1:0] data_in = '0;
  logic in_ready, channel_out, busy, frame_done;
  int tests = 0, fails = 0;
  serial_tx #(.BIT_LEN(BL), .IDLE_GAP(GAPN)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .channel_out(channel_out), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a scheduled list of future line cycles {done,bit}; a frame is scheduled when the line is free and a word is held.
  logic [1:0] line[$];
  logic [BL-1:0] m_hold, m_w;
  logic [BL-1:0] sent_q[$];
  logic m_full = 0, m_ch = 0, m_busy = 0, m_done = 0, m_ready = 1, m_acc = 0;
  always @(posedge clk) begin
    m_acc = 0;
    if (rst) begin
      line.delete();
      m_full = 0; m_ch = 0; m_busy = 0; m_done = 0; m_ready = 1;
    end else begin
      if (line.size() == 0 && m_full) begin
        m_w = m_hold;
        line.push_back(2'b01);
        for (int i = 0; i < BL; i++) line.push_back({1'b0, m_w[i]});
        line.push_back({1'b0, ^m_w});
        line.push_back(2'b01);
        for (int g = 0; g < GAPN; g++) line.push_back({g == GAPN - 1, 1'b0});
        m_full = 0;
      end
      if (line.size() > 0) begin
        {m_done, m_ch} = line.pop_front();
        m_busy = 1;
      end else begin
        m_done = 0; m_ch = 0; m_busy = 0;
      end
      if (in_valid && m_ready) begin
        m_hold = data_in; m_full = 1; m_acc = 1;
        sent_q.push_back(data_in);
      end
      m_ready = !m_full;
    end
  end

  logic chk_en = 0;
  always @(negedge clk) if (chk_en) begin
    chk("channel_out", channel_out, m_ch);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_done);
    chk("in_ready", in_ready, m_ready);
  end

  // Independent receiver: decodes frames off the line and checks them against accepted words in order.
  logic rx_en = 0, rx_act = 0;
  logic [8:0] rx_bits;
  int rx_n = 0, rx_cnt = 0;
  always @(negedge clk) if (rx_en) begin
    if (!rx_act) begin
      if (channel_out) begin rx_act = 1; rx_n = 0; end
    end else begin
      rx_bits[rx_n] = channel_out;
      rx_n++;
      if (rx_n == BL + 2) begin
        rx_act = 0;
        chk("rx_parity", {31'b0, ^rx_bits[BL:0]}, 0);
        chk("rx_stop", {31'b0, rx_bits[BL+1]}, 1);
        chk("rx_data", {25'b0, rx_bits[BL-1:0]}, sent_q.size() > 0 ? {25'b0, sent_q.pop_front()} : 32'hx);
        rx_cnt++;
      end
    end
  end

  task automatic send(input logic [BL-1:0] d);
    int n = 0;
    in_valid = 1; data_in = d;
    do begin @(negedge clk); n++; end while (!m_acc && n < 100);
    if (!m_acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic cap(input int n, output logic [31:0] ch, output logic [31:0] dn);
    ch = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ch[i] = channel_out;
      dn[i] = frame_done;
    end
  endtask

  logic [31:0] ch, dn;
  initial begin
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ch", channel_out, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_done", frame_done, 0);
    end
    send(7'h55); cap(11, ch, dn);
    chk("frame_55", ch[10:0], 11'b01010101011);
    chk("done_55", dn[10:0], 11'b10000000000);
    send(7'h07); cap(11, ch, dn);
    chk("frame_07", ch[10:0], 11'b01100001111);
    send(7'h00); cap(11, ch, dn);
    chk("frame_00", ch[10:0], 11'b01000000001);
    chk("done_00", dn[10:0], 11'b10000000000);
    send(7'h01);
    fork
      send(7'h7F);
      cap(22, ch, dn);
    join
    chk("b2b_ch", ch[20:9], 12'b111111111101);
    chk("b2b_done", {dn[21], dn[10]}, 2'b11);
    repeat (3) @(negedge clk);
    send(7'h55);
    send(7'h2A);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_ch", channel_out, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_busy", busy, 0);
    rst = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_rst_ch", channel_out, 0);
    end
    sent_q.delete();
    rx_en = 1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(BL'($urandom));
    end
    for (int i = 0; i < 100 && rx_cnt < 200; i++) @(negedge clk);
    chk("rx_count", rx_cnt, 200);
    chk("rx_leftover", sent_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
